pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer for the 16 MHz -> 10 MHz PLL (SB_PLL40_CORE instance, active-low RESETB, LOCK output).
- Holds the PLL in reset, waits for a qualified lock, then raises CLK_READY. Downstream logic on the 10 MHz domain uses CLK_READY as its reset release.
- Retries on lock timeout, latches a sticky fault after repeated failures, and re-sequences on loss of lock.
- Runs on the 16 MHz reference clock, upstream of the PLL wrapper.

Parameters:
- HOLD_CYCLES, 16: number of cycles PLL_RESETB is held low per attempt (>=2).
- STABLE_CYCLES, 64: number of consecutive synchronized-LOCK-high cycles required to qualify lock.
- TIMEOUT_CYCLES, 4096: number of cycles allowed in WAIT_LOCK before the attempt fails.
- MAX_RETRIES, 3: number of failed attempts tolerated before FAULT. Range 1..15.
- BYPASS_ON_FAULT, 1: when 1, PLL_BYPASS is driven high while in FAULT.
- CNT_W, 13: width of the shared cycle counter. Must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- REFERENCECLK  input  1  16 MHz reference clock; the only clock.
- RESET  input  1  synchronous reset, active low.
- PLL_LOCK  input  1  PLL LOCK output; asynchronous to REFERENCECLK.
- RETRY_REQ  input  1  single-cycle pulse; leaves FAULT, ignored in all other states.
- PLL_RESETB  output  1  drives PLL RESETB; active low.
- PLL_BYPASS  output  1  drives PLL BYPASS.
- CLK_READY  output  1  high only in RUN.
- FAULT  output  1  high only in FAULT.
- RETRY_COUNT  output  4  failed attempts since the last RUN entry or reset.
- LOSS_COUNT  output  8  lock-loss events in RUN; saturates at 255.
- STATE  output  2  current state: HOLD=0, WAIT_LOCK=1, RUN=2, FAULT=3.

Behaviour:
- Reset (RESET=0 sampled on a REFERENCECLK edge):
  - STATE=HOLD, counter=0, stable count=0, sync flops=0.
  - PLL_RESETB=0, PLL_BYPASS=0, CLK_READY=0, FAULT=0, RETRY_COUNT=0, LOSS_COUNT=0.
  - Reset mid-operation has the same effect from any state.
- Synchronizer:
  - PLL_LOCK passes through 2 flops to give lock_s.
  - All decisions use lock_s only, so there is 2 cycles of latency from a PLL_LOCK edge to any reaction.
- Counter: the cycle counter clears on every state entry.
- All outputs are registered. They are decoded from the next state, so each output changes on the same edge as STATE.
- HOLD:
  - PLL_RESETB=0.
  - Counter increments each cycle. When counter==HOLD_CYCLES-1, go to WAIT_LOCK.
  - PLL_RESETB is therefore low for exactly HOLD_CYCLES cycles.
- WAIT_LOCK:
  - PLL_RESETB=1; counter increments each cycle.
  - Stable count increments while lock_s=1 and clears to 0 on any lock_s=0.
  - If lock_s=1 and stable count==STABLE_CYCLES-1: go to RUN.
  - Otherwise, if counter==TIMEOUT_CYCLES-1, the attempt has failed:
    - if RETRY_COUNT==MAX_RETRIES: go to FAULT;
    - else RETRY_COUNT+=1 and go to HOLD.
  - Simultaneous qualify and timeout on the same cycle: qualify wins, go to RUN.
- RUN:
  - CLK_READY=1, PLL_RESETB=1.
  - RETRY_COUNT clears on entry.
  - Any cycle with lock_s=0: LOSS_COUNT+=1 (saturating), go to HOLD. CLK_READY falls on that same edge.
- FAULT:
  - FAULT=1, PLL_RESETB=0, PLL_BYPASS=BYPASS_ON_FAULT.
  - Sticky until RESET or RETRY_REQ.
  - On RETRY_REQ=1: clear RETRY_COUNT, go to HOLD. LOSS_COUNT is preserved.
- Glitch rule: lock_s glitches in WAIT_LOCK only restart qualification; they never count as an attempt failure.
- Counting rule: exactly MAX_RETRIES+1 attempts are made before FAULT.
- PLL_BYPASS=0 in every state except FAULT.

Test Plan:
1. Normal lock:
   - Stimulus: defaults; release RESET; PLL_LOCK rises 100 cycles after PLL_RESETB rises.
   - Response: PLL_RESETB low for exactly 16 cycles; CLK_READY rises 2+64 cycles after the PLL_LOCK edge; RETRY_COUNT=0.
2. Lock glitch:
   - Stimulus: in WAIT_LOCK, PLL_LOCK high 40 cycles, low 1 cycle, then high.
   - Response: qualification restarts; CLK_READY rises 64 cycles after lock_s returns high; no retry counted.
3. Timeout to FAULT:
   - Stimulus: PLL_LOCK held 0.
   - Response: 4 attempts; RETRY_COUNT steps 1, 2, 3; then FAULT=1, PLL_BYPASS=1, PLL_RESETB=0, STATE=3, held for 10000 cycles.
4. Retry from FAULT:
   - Stimulus: from scenario 3, pulse RETRY_REQ, then PLL_LOCK=1.
   - Response: STATE=HOLD on the next edge; FAULT=0 and RETRY_COUNT=0; RUN reached after 16+64+2 cycles (within the same bounds as scenario 1).
5. Loss of lock:
   - Stimulus: in RUN, drop PLL_LOCK for 5 cycles.
   - Response: CLK_READY falls 2 cycles after the PLL_LOCK fall edge plus one state-update edge; LOSS_COUNT=1; full HOLD/WAIT_LOCK sequence re-runs; 300 forced losses give LOSS_COUNT=255.
6. Qualify/timeout collision and mid-run reset:
   - Stimulus: time lock_s so the stable count hits 63 on the same cycle as counter 4095; separately, assert RESET in RUN.
   - Response: collision goes to RUN with RETRY_COUNT unchanged; RESET gives the all-zero outputs and STATE=0 on the next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pll_lock_sequencer
//  Brief    : Holds the PLL in reset, qualifies LOCK, raises CLK_READY,
//             retries on timeout and latches a sticky fault.
//  Revision : 1.0
// ============================================================================
module pll_lock_sequencer #(
    parameter int HOLD_CYCLES     = 16,
    parameter int STABLE_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int MAX_RETRIES     = 3,
    parameter int BYPASS_ON_FAULT = 1,
    parameter int CNT_W           = 13
) (
    input  logic       REFERENCECLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       RETRY_REQ,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       CLK_READY,
    output logic       FAULT,
    output logic [3:0] RETRY_COUNT,
    output logic [7:0] LOSS_COUNT,
    output logic [1:0] STATE
);

    localparam int STB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] c_stable_last  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       c_max_retries  = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_lock_s;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [STB_W-1:0] r_stable, w_stable_nxt;
    logic [3:0]       r_retry, w_retry_nxt;
    logic [7:0]       r_loss, w_loss_nxt;
    logic             r_resetb, r_bypass, r_ready, r_fault;

    always_ff @(posedge REFERENCECLK) begin
        if (!RESET) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_stable <= '0;
            r_retry  <= '0;
            r_loss   <= '0;
            r_resetb <= 1'b0;
            r_bypass <= 1'b0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_sync1  <= PLL_LOCK;
            r_lock_s <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_retry  <= w_retry_nxt;
            r_loss   <= w_loss_nxt;
            // Outputs follow the next state so they move on the same edge as STATE
            r_resetb <= (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_RUN);
            r_bypass <= (w_state_nxt == ST_FAULT) && (BYPASS_ON_FAULT != 0);
            r_ready  <= (w_state_nxt == ST_RUN);
            r_fault  <= (w_state_nxt == ST_FAULT);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = '0;
        w_retry_nxt  = r_retry;
        w_loss_nxt   = r_loss;
        case (r_state)
            ST_HOLD: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                w_cnt_nxt    = r_cnt + 1'b1;
                w_stable_nxt = r_lock_s ? r_stable + 1'b1 : '0;
                // Qualification takes priority over a coincident timeout
                if (r_lock_s && (r_stable == c_stable_last)) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = '0;
                end else if (r_cnt == c_timeout_last) begin
                    if (r_retry == c_max_retries) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_HOLD;
                    if (r_loss != 8'hFF) begin
                        w_loss_nxt = r_loss + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (RETRY_REQ) begin
                    w_state_nxt = ST_HOLD;
                    w_retry_nxt = '0;
                end
            end
            default: w_state_nxt = ST_HOLD;
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt    = '0;
            w_stable_nxt = '0;
        end
    end

    assign PLL_RESETB  = r_resetb;
    assign PLL_BYPASS  = r_bypass;
    assign CLK_READY   = r_ready;
    assign FAULT       = r_fault;
    assign RETRY_COUNT = r_retry;
    assign LOSS_COUNT  = r_loss;
    assign STATE       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pll_lock_sequencer
//  Brief    : Directed vector table plus hand sequences for pll_lock_sequencer.
//  Revision : 1.0
// ============================================================================
module tb_pll_lock_sequencer;

    localparam logic [1:0] S_HOLD = 2'd0, S_WAIT = 2'd1, S_RUN = 2'd2, S_FAULT = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n, pll_lock, retry_req;
    logic       pll_resetb, pll_bypass, clk_ready, fault;
    logic [3:0] retry_count;
    logic [7:0] loss_count;
    logic [1:0] state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer dut (
        .REFERENCECLK (clk),
        .RESET        (rst_n),
        .PLL_LOCK     (pll_lock),
        .RETRY_REQ    (retry_req),
        .PLL_RESETB   (pll_resetb),
        .PLL_BYPASS   (pll_bypass),
        .CLK_READY    (clk_ready),
        .FAULT        (fault),
        .RETRY_COUNT  (retry_count),
        .LOSS_COUNT   (loss_count),
        .STATE        (state)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic       lock;
        logic       req;
        int         cycles;
        logic [1:0] st;
        logic [3:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input string n, input logic r, input logic l, input logic q,
                                input int c, input logic [1:0] s, input logic [3:0] rc,
                                input logic [7:0] lc);
        vec_t v;
        v.name = n; v.rst_n = r; v.lock = l; v.req = q; v.cycles = c;
        v.st = s; v.rc = rc; v.lc = lc;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full expected output word for a given state and counters
    task automatic check(input string name, input logic [1:0] st, input logic [3:0] rc,
                         input logic [7:0] lc);
        logic [17:0] act, exp;
        logic e_rb, e_bp, e_rdy, e_flt;
        e_rb  = (st == S_WAIT) || (st == S_RUN);
        e_bp  = (st == S_FAULT);
        e_rdy = (st == S_RUN);
        e_flt = (st == S_FAULT);
        exp = {st, e_rb, e_bp, e_rdy, e_flt, rc, lc};
        act = {state, pll_resetb, pll_bypass, clk_ready, fault, retry_count, loss_count};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%0d rb=%b bp=%b rdy=%b flt=%b rc=%0d lc=%0d, want st=%0d rb=%b bp=%b rdy=%b flt=%b rc=%0d lc=%0d",
                     name, state, pll_resetb, pll_bypass, clk_ready, fault, retry_count, loss_count,
                     st, e_rb, e_bp, e_rdy, e_flt, rc, lc);
        end
    endtask

    initial begin
        rst_n = 1'b0; pll_lock = 1'b0; retry_req = 1'b0;

        //             name             rst lock req cyc  state   rc lc
        tbl[0]  = mk("reset",          0,  0,  0,  3,   S_HOLD, 0, 0);
        tbl[1]  = mk("hold_low",       1,  0,  0,  15,  S_HOLD, 0, 0);
        tbl[2]  = mk("hold_end",       1,  0,  0,  1,   S_WAIT, 0, 0);
        tbl[3]  = mk("pre_lock",       1,  0,  0,  100, S_WAIT, 0, 0);
        tbl[4]  = mk("qualifying",     1,  1,  0,  65,  S_WAIT, 0, 0);
        tbl[5]  = mk("lock_run",       1,  1,  0,  1,   S_RUN,  0, 0);
        tbl[6]  = mk("loss_sync",      1,  0,  0,  2,   S_RUN,  0, 0);
        tbl[7]  = mk("loss_hold",      1,  0,  0,  1,   S_HOLD, 0, 1);
        tbl[8]  = mk("loss_low",       1,  0,  0,  2,   S_HOLD, 0, 1);
        tbl[9]  = mk("relock_hold",    1,  1,  0,  13,  S_HOLD, 0, 1);
        tbl[10] = mk("relock_wait",    1,  1,  0,  1,   S_WAIT, 0, 1);
        tbl[11] = mk("requal",         1,  1,  0,  63,  S_WAIT, 0, 1);
        tbl[12] = mk("rerun",          1,  1,  0,  1,   S_RUN,  0, 1);
        tbl[13] = mk("midrun_rst",     0,  1,  0,  1,   S_HOLD, 0, 0);
        tbl[14] = mk("req_ignored",    1,  0,  1,  16,  S_WAIT, 0, 0);
        tbl[15] = mk("glitch_high",    1,  1,  0,  40,  S_WAIT, 0, 0);
        tbl[16] = mk("glitch_low",     1,  0,  0,  1,   S_WAIT, 0, 0);
        tbl[17] = mk("glitch_requal",  1,  1,  0,  65,  S_WAIT, 0, 0);
        tbl[18] = mk("glitch_run",     1,  1,  0,  1,   S_RUN,  0, 0);

        for (int i = 0; i < 19; i++) begin
            rst_n = tbl[i].rst_n; pll_lock = tbl[i].lock; retry_req = tbl[i].req;
            step(tbl[i].cycles);
            check(tbl[i].name, tbl[i].st, tbl[i].rc, tbl[i].lc);
        end

        // Timeout path: four attempts of 16 + 4096 cycles each, then FAULT
        rst_n = 1'b0; pll_lock = 1'b0; retry_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(16);
        check("to_first_wait", S_WAIT, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(4095);
            check("to_wait_end", S_WAIT, 4'(k - 1), 0);
            step(1);
            if (k < 4) begin
                check("to_retry_hold", S_HOLD, 4'(k), 0);
                step(16);
                check("to_retry_wait", S_WAIT, 4'(k), 0);
            end else begin
                check("to_fault", S_FAULT, 3, 0);
            end
        end
        pll_lock = 1'b1;
        step(10000);
        check("fault_sticky", S_FAULT, 3, 0);

        // Retry request leaves FAULT
        pll_lock = 1'b0; retry_req = 1'b1;
        step(1);
        check("retry_hold", S_HOLD, 0, 0);
        retry_req = 1'b0;
        step(15);
        check("retry_hold_end", S_HOLD, 0, 0);
        step(1);
        check("retry_wait", S_WAIT, 0, 0);
        pll_lock = 1'b1;
        step(65);
        check("retry_qual", S_WAIT, 0, 0);
        step(1);
        check("retry_run", S_RUN, 0, 0);

        // Qualify lands on the same cycle as the timeout
        rst_n = 1'b0; pll_lock = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(16);
        step(4030);
        pll_lock = 1'b1;
        step(65);
        check("coll_pre", S_WAIT, 0, 0);
        step(1);
        check("coll_run", S_RUN, 0, 0);

        // Repeated lock loss saturates LOSS_COUNT
        for (int i = 1; i <= 300; i++) begin
            pll_lock = 1'b0;
            step(3);
            check("sat_loss", S_HOLD, 0, (i > 255) ? 8'd255 : 8'(i));
            pll_lock = 1'b1;
            step(80);
            if (i == 300) check("sat_run", S_RUN, 0, 255);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
